// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = LEN_BYTES * 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * 8;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  // States in which the loader accepts stream bytes
  function automatic logic accepts_bytes(input state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a byte stream into little-endian words; flags the byte that completes a word.
module imem_loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [BYTE_IDX_W-1:0] idx_q;
  logic [WORD_W-1:0]     buf_q;

  // Current word with the incoming byte merged into its lane
  always_comb begin
    word_c = buf_q;
    word_c[{idx_q, 3'b000} +: 8] = byte_data;
  end

  assign word_valid_c = byte_valid && (idx_q == LAST_IDX);

  // Lane index and assembly buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      buf_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
      buf_q <= '0;
    end else if (byte_valid) begin
      idx_q <= idx_q + BYTE_IDX_W'(1);
      buf_q <= word_c;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses length/data/checksum byte stream into instruction memory
// writes and releases the processor reset once the image verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   word_idx_q, word_idx_d;
  logic [7:0]         csum_q, csum_d;

  logic               ready_d, we_d, cpu_reset_d, done_d, error_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [31:0]        wdata_d;

  logic               hs_c, restart_c, pk_byte_valid_c;
  logic [CNT_W-1:0]   len_full_c;
  logic               word_valid_c;
  logic [WORD_W-1:0]  word_c;

  assign hs_c            = in_valid && in_ready;
  assign restart_c       = restart && (state_q != ST_IDLE);
  assign pk_byte_valid_c = hs_c && !restart_c && (state_q == ST_DATA);
  assign len_full_c      = {in_data, len_q[7:0]};

  imem_loader_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (restart_c),
    .byte_valid   (pk_byte_valid_c),
    .byte_data    (in_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, datapath updates and next output values
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;

    if (restart_c) begin
      state_d    = ST_LEN_LO;
      len_d      = '0;
      word_idx_d = '0;
      csum_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_LEN_LO;
        ST_LEN_LO: begin
          if (hs_c) begin
            len_d   = CNT_W'(in_data);
            state_d = ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (hs_c) begin
            len_d = len_full_c;
            if (32'(len_full_c) > DEPTH) begin
              state_d = ST_ERROR;
            end else if (len_full_c == '0) begin
              state_d = ST_CHECK;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (hs_c) begin
            csum_d = csum_q ^ in_data;
            if (word_valid_c) begin
              we_d       = 1'b1;
              addr_d     = ADDR_W'({word_idx_q, 2'b00});
              wdata_d    = word_c;
              word_idx_d = word_idx_q + CNT_W'(1);
              if (word_idx_q == len_q - CNT_W'(1)) begin
                state_d = ST_CHECK;
              end
            end
          end
        end
        ST_CHECK: begin
          if (hs_c) begin
            state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
          end
        end
        default: ;
      endcase
    end

    ready_d     = accepts_bytes(state_d);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERROR);
    cpu_reset_d = (state_d != ST_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q      <= '0;
      word_idx_q <= '0;
      csum_q     <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      csum_q     <= csum_d;
      in_ready   <= ready_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      cpu_reset  <= cpu_reset_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a stream-level model queues expected writes,
// a monitor checks every write strobe; final status checked after each image.
module tb_imem_loader;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              restart;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .restart    (restart),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          pos;
  } wr_t;

  wr_t  wq[$];
  int   hs_cyc [0:2047];
  logic exp_done, exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue
  logic prev_we = 1'b0;
  initial begin
    forever begin
      wr_t e;
      @(negedge clk);
      if (reset === 1'b1 && imem_we === 1'b1) begin
        check("we_single_cycle", 32'(prev_we), 32'd0);
        if (wq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", imem_addr, imem_wdata);
        end else begin
          e = wq.pop_front();
          check("wr_addr", imem_addr, e.addr);
          check("wr_data", imem_wdata, e.data);
          check("wr_latency", 32'(cyc), 32'(hs_cyc[e.pos]));
        end
      end
      prev_we = (reset === 1'b1) && (imem_we === 1'b1);
    end
  end

  // Stream-level reference: expected writes and final verdict
  task automatic model(input logic [7:0] s[$]);
    int         n;
    logic [7:0] cs;
    wr_t        e;
    n = int'({s[1], s[0]});
    if (n > int'(DEPTH)) begin
      exp_err  = 1'b1;
      exp_done = 1'b0;
      return;
    end
    cs = 8'h00;
    for (int k = 0; k < n; k++) begin
      e.addr = 32'(k * 4);
      e.data = {s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]};
      e.pos  = 2 + 4*k + 3;
      for (int b = 0; b < 4; b++) cs = cs ^ s[2+4*k+b];
      wq.push_back(e);
    end
    exp_done = (s[2+4*n] == cs);
    exp_err  = !exp_done;
  endtask

  // Drive bytes; gap = percent chance of idle cycle, or -1 for alternate-cycle gaps
  task automatic send(input logic [7:0] s[$], input int gap, input int nbytes);
    int   lim;
    int   waited;
    logic hs;
    lim = (nbytes < 0) ? s.size() : nbytes;
    for (int i = 0; i < lim; i++) begin
      if (gap < 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end else begin
        while ($urandom_range(99) < gap) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = s[i];
      waited   = 0;
      forever begin
        hs = in_ready;
        @(posedge clk);
        #1;
        if (hs) break;
        waited++;
        if (waited > 20) begin
          n_cmp++;
          n_fail++;
          $display("FAIL in_ready_timeout: byte %0d never accepted, in_ready=%0b", i, in_ready);
          in_valid = 1'b0;
          @(negedge clk);
          return;
        end
        @(negedge clk);
      end
      hs_cyc[i] = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_final();
    check("done", 32'(done), 32'(exp_done));
    check("error", 32'(error), 32'(exp_err));
    check("cpu_reset", 32'(cpu_reset), 32'(!exp_done));
    check("in_ready_terminal", 32'(in_ready), 32'd0);
    check("writes_drained", 32'(wq.size()), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    check_reset_values();
    reset = 1'b1;
  endtask

  // Single-cycle restart pulse, optionally with a competing valid byte
  task automatic do_restart(input bit v);
    restart  = 1'b1;
    in_valid = v;
    in_data  = 8'h01;
    @(posedge clk);
    @(negedge clk);
    restart  = 1'b0;
    in_valid = 1'b0;
    check("rs_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rs_done", 32'(done), 32'd0);
    check("rs_error", 32'(error), 32'd0);
    check("rs_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic make_img(input int n, input bit good, output logic [7:0] s[$]);
    logic [7:0] cs;
    logic [7:0] b;
    s = {};
    s.push_back(8'(n));
    s.push_back(8'(n >> 8));
    cs = 8'h00;
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      cs = cs ^ b;
      s.push_back(b);
    end
    s.push_back(good ? cs : (cs ^ 8'(1 + $urandom_range(254))));
  endtask

  initial begin
    logic [7:0] s1[$];
    logic [7:0] s[$];
    logic [15:0] n16;
    s1 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; restart = 1'b0;
    #2;
    do_reset();

    // Two-word image, good checksum
    model(s1); send(s1, 0, -1); check_final();

    // Same image, bad checksum
    do_restart(1'b0);
    s = s1; s[10] = 8'h70;
    model(s); send(s, 0, -1); check_final();

    // Empty image
    do_restart(1'b0);
    s = '{8'h00, 8'h00, 8'h00};
    model(s); send(s, 0, -1); check_final();

    // Oversize length
    do_restart(1'b0);
    s = '{8'h01, 8'h01};
    model(s); send(s, 0, -1); check_final();

    // Alternate-cycle valid gaps
    do_restart(1'b0);
    model(s1); send(s1, -1, -1); check_final();

    // Reset mid-load, then full reload
    do_restart(1'b0);
    model(s1); send(s1, 0, 6);
    @(negedge clk); #1;
    check("midload_pending", 32'(wq.size()), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_values();
    wq.delete();
    @(negedge clk);
    do_reset();
    model(s1); send(s1, 0, -1); check_final();

    // Restart with a competing byte, then one-word image
    do_restart(1'b1);
    s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    model(s); send(s, 0, -1); check_final();

    // Maximum-size image
    do_restart(1'b0);
    make_img(DEPTH, 1'b1, s);
    model(s); send(s, 0, -1); check_final();

    // Randomized images
    for (int it = 0; it < 14; it++) begin
      do_restart(1'($urandom_range(1)));
      if ($urandom_range(6) == 0) begin
        n16 = 16'($urandom_range(65535, DEPTH + 1));
        s = '{n16[7:0], n16[15:8]};
      end else begin
        make_img($urandom_range(6), $urandom_range(3) != 0, s);
      end
      model(s);
      send(s, $urandom_range(50), -1);
      check_final();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched so far", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
